// File: rtl/matrix_pkg.sv
// Shared constants and arbiter state encoding for clients of the 6x6 LED matrix.
// Other matrix clients import this to decode busy and the arbiter states.
package matrix_pkg;

    localparam int DIM_X = 6;
    localparam int DIM_Y = 6;
    localparam int IMG_W = DIM_X * DIM_Y;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_OWN   = 2'd2
    } arb_state_e;

    function automatic logic is_busy(input arb_state_e s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/matrix_frame_arbiter_if.sv
// Requester-side bundle of the frame arbiter: level requests and frames in,
// grant, owner, busy and the selected frame out.
interface matrix_frame_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IMG_W   = matrix_pkg::IMG_W
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*IMG_W-1:0] img_in;
    logic [NUM_REQ-1:0]       grant;
    logic [OW-1:0]            owner;
    logic                     busy;
    logic [IMG_W-1:0]         img_out;

    modport master (
        output req, img_in,
        input  grant, owner, busy, img_out
    );

    modport slave (
        input  req, img_in,
        output grant, owner, busy, img_out
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set req bit after owner, wrapping,
// so the current owner is considered last.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      owner,
    output logic               found,
    output logic [IW-1:0]      idx
);

    always_comb begin
        int cand;
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(owner) + k) % NUM_REQ;
            if (!found && req[cand[IW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/matrix_frame_arbiter.sv
// Shares one 6x6 LED matrix between NUM_REQ frame producers: round-robin ownership
// with a minimum dwell time and a dark gap of BLANK_CYCLES on every hand-over.
module matrix_frame_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IMG_W        = matrix_pkg::IMG_W,
    parameter int HOLD_CYCLES  = 12_000_000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    matrix_frame_arbiter_if.slave bus
);
    import matrix_pkg::*;

    // state    | meaning
    // ST_IDLE  | no owner, matrix dark, waiting for any request
    // ST_BLANK | candidate held in owner_q, matrix forced dark for BLANK_CYCLES
    // ST_OWN   | owner_q granted, its live frame passes through to img_out

    localparam int OW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam int BLANK_W   = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

    arb_state_e          state_q, state_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                busy_q, busy_d;
    logic [IMG_W-1:0]    img_out_q, img_out_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [BLANK_W-1:0]  blank_cnt_q, blank_cnt_d;

    logic                pick_found;
    logic [OW-1:0]       pick_idx;
    logic                own_req;
    logic                others;
    logic [HOLD_W-1:0]   hold_inc;
    logic                hold_hit;
    logic                blank_done;
    logic                hand_over;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (OW)
    ) u_rr_pick (
        .req   (bus.req),
        .owner (owner_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign own_req    = bus.req[owner_q];
    assign others     = |(bus.req & ~(NUM_REQ'(1) << owner_q));
    assign hold_hit   = (hold_inc == HOLD_W'(HOLD_CYCLES));
    assign blank_done = (blank_cnt_q == BLANK_W'(BLANK_CYCLES - 1));

    // Saturate so a lone owner can sit in OWN forever without the counter wrapping.
    always_comb begin
        if (hold_cnt_q == HOLD_W'(HOLD_CYCLES)) begin
            hold_inc = hold_cnt_q;
        end else begin
            hold_inc = hold_cnt_q + HOLD_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        hold_cnt_d  = hold_cnt_q;
        blank_cnt_d = blank_cnt_q;
        hand_over   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    hand_over = 1'b1;
                end
            end
            ST_BLANK: begin
                if (!blank_done) begin
                    blank_cnt_d = blank_cnt_q + BLANK_W'(1);
                end else if (own_req) begin
                    state_d = ST_OWN;
                end else if (pick_found) begin
                    hand_over = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (!own_req || (hold_hit && others)) begin
                    if (others) begin
                        hand_over = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    hold_cnt_d = hold_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (hand_over) begin
            owner_d     = pick_idx;
            blank_cnt_d = '0;
            state_d     = HAS_BLANK ? ST_BLANK : ST_OWN;
        end

        if (hand_over || state_d != ST_OWN) begin
            hold_cnt_d = '0;
        end

        grant_d = (state_d == ST_OWN) ? (NUM_REQ'(1) << owner_d) : '0;
        busy_d  = is_busy(state_d);
        // Frames pass through only while ownership continues; a fresh grant starts dark.
        if (state_q == ST_OWN && state_d == ST_OWN) begin
            img_out_d = IMG_W'(bus.img_in >> (owner_d * IMG_W));
        end else begin
            img_out_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OW'(NUM_REQ - 1);
            grant_q     <= '0;
            busy_q      <= 1'b0;
            img_out_q   <= '0;
            hold_cnt_q  <= '0;
            blank_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            img_out_q   <= img_out_d;
            hold_cnt_q  <= hold_cnt_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = busy_q;
    assign bus.img_out = img_out_q;

endmodule

// File: doc/matrix_frame_arbiter.md
# matrix_frame_arbiter

Shares the single 6×6 LED matrix between several image producers, such as the game renderer, countdown digits and status faces. It sits directly in front of `ledMatrix` and drives its 36-bit `img` input. Requesters raise a level request together with their frame. The block grants exactly one owner at a time using round-robin, enforces a minimum dwell time per owner, and inserts a blank gap on every hand-over so that frames do not visibly smear together.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `IMG_W`, 36: frame width in bits (6 rows × 6 columns, row 0 in bits [5:0]).
- `HOLD_CYCLES`, 12_000_000: minimum number of cycles an owner keeps the matrix before it can be pre-empted; must be ≥1.
- `BLANK_CYCLES`, 1000: number of cycles `img_out` is forced to 0 between owners; 0 disables the gap.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `req` in NUM_REQ: level request, one bit per requester.
- `img_in` in NUM_REQ*IMG_W: frame of requester i at bits [i*IMG_W +: IMG_W].
- `grant` out NUM_REQ: one-hot grant, registered.
- `owner` out clog2(NUM_REQ): index of the current or last owner.
- `busy` out 1: high in the BLANK and OWN states.
- `img_out` out IMG_W: frame sent to `ledMatrix`, registered.

## Operation
- States: IDLE, BLANK, OWN.
- Reset values: state=IDLE, `grant`=0, `owner`=NUM_REQ-1 (so requester 0 is searched first), `busy`=0, `img_out`=0, hold and blank counters=0.
- Round-robin pick: first asserted `req` bit scanning from `owner`+1 upward, wrapping modulo NUM_REQ. The current owner has the lowest priority and is only re-picked when it is the sole requester.
- IDLE:
  - `img_out`=0.
  - Any `req` → latch the pick into `owner`.
  - Go to BLANK if BLANK_CYCLES>0, otherwise directly to OWN.
- BLANK:
  - `img_out`=0 and `grant`=0.
  - Counter runs 0..BLANK_CYCLES-1.
  - At the end: if `req[owner]` is still high → OWN.
  - Else if any other `req` is high → re-pick and restart BLANK.
  - Else → IDLE.
- OWN:
  - `grant[owner]`=1.
  - `img_out` ← owner's slice of `img_in` every cycle, so live frames pass through.
  - Hold counter increments, saturating at HOLD_CYCLES.
  - Owner drops `req` → release immediately, regardless of the hold count.
  - Hold counter has reached HOLD_CYCLES and another `req` is pending → pre-empt.
  - On release or pre-empt: if another request is pending → pick it, go to BLANK (or OWN when BLANK_CYCLES=0), and clear the hold counter; else → IDLE.
  - Sole owner keeps its request → stays in OWN indefinitely.
- Owner drops `req` in the same cycle another requester raises one: the hand-over goes to the new requester; the block does not pass through IDLE.
- Requests from non-owners are never lost; they wait in the round-robin order.
- `req` bits at or above NUM_REQ do not exist; all `req` bits are treated as sampled levels.

## Timing
- `req` change → `grant` and state update on the next rising edge (1-cycle latency).
- `grant` deasserts in the same cycle that `img_out` goes to 0 or switches source.
- `img_in` slice → `img_out`: 1-cycle latency while in OWN.
- A hand-over takes exactly BLANK_CYCLES+1 cycles from the deciding edge until the new `grant` rises. With BLANK_CYCLES=0 this is 1 cycle, with no blank frame.
- `rst_n` low mid-operation forces all outputs to their reset values asynchronously. Arbitration restarts from IDLE on the first edge after release.
- Counter widths are clog2(max+1); they never wrap.

## Structure
- Shared package `matrix_pkg`: the IMG_W=36, DIM_X=6 and DIM_Y=6 constants, and the state encoding (IDLE, BLANK, OWN) so that other matrix clients can decode `busy` and the states.
- One sub-module, `rr_pick`: combinational round-robin finder taking `req` and `owner` and returning `found` and `idx`. It is reusable by a future button/event arbiter.
- Hold counter, blank counter and the FSM live in `matrix_frame_arbiter`.

## Test plan
Benches use NUM_REQ=4, HOLD_CYCLES=8 and BLANK_CYCLES=2 unless noted.
- Reset with no requests, hold 20 cycles → `grant`=0, `img_out`=0, `busy`=0 throughout.
- Single request: `req`=0001 with img_in[0]=36'h0_0000_0481 → 2 blank cycles, then `grant`=0001, then `img_out`=36'h0_0000_0481 one cycle later. Change that slice while owned → `img_out` follows with a 1-cycle lag.
- Pre-emption: `req`=0011 from IDLE → requester 0 owns for 8 cycles, 2 blank cycles, then requester 1, then back to requester 0 after a further 8 cycles.
- Early release and wrap: owner 3 drops `req` at hold count 3 while `req[1]` is high → BLANK starts next cycle; `grant`=0010 after 3 cycles; the pick wraps past index 0.
- Simultaneous drop/raise: owner 0 drops as requester 2 raises in the same cycle → `busy` stays high, no IDLE state is visited, and `grant`=0100. Repeat with BLANK_CYCLES=0 → `grant` moves from 0001 to 0100 in 1 cycle.
- Candidate vanishes during BLANK: the picked requester drops during the gap while another request is pending → re-pick and restart BLANK. With no other request pending → IDLE. Asserting `rst_n`=0 mid-OWN → `grant` and `img_out` go to 0 immediately, without waiting for a clock edge.
